dm_sized: RTL
=============

DM_SIZED -- requirements
Module: dm_sized

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words (power of two, 4..4096).
REQ-002 SHALL have parameter IDX_W, default $clog2(DEPTH), meaning word-index width (derived, not overridden).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port addr  input  32  byte address.
REQ-006 SHALL have port data_in  input  32  store data, right-aligned.
REQ-007 SHALL have port memWrite  input  1  store request.
REQ-008 SHALL have port memRead  input  1  load request.
REQ-009 SHALL have port size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-010 SHALL have port ld_unsigned  input  1  1 = zero-extend loads, 0 = sign-extend.
REQ-011 SHALL have port dm_out  output  32  load result, right-aligned and extended.
REQ-012 SHALL have port busy  output  1  clear sweep in progress.
REQ-013 SHALL have port misalign  output  1  illegal access flag.

Function
REQ-014 SHALL use word index addr[IDX_W+1:2]; higher address bits ignored (aliasing wrap).
REQ-015 SHALL use little-endian byte lanes: lane n = addr[1:0]==n = bits [8n+7:8n].
REQ-016 SHALL assert misalign combinationally when (memRead|memWrite) and (size==01 & addr[0]) or (size==10 & addr[1:0]!=0) or size==11; otherwise 0.
REQ-017 SHALL store on rising clk when memWrite & !misalign & !busy & !rst: byte writes lane addr[1:0] with data_in[7:0]; half writes lanes addr[1]*2..+1 with data_in[15:0]; word writes all lanes; unaddressed lanes unchanged.
REQ-018 SHALL suppress the store entirely on misalign; no partial write.
REQ-019 SHALL produce dm_out combinationally (zero-latency read) when memRead & !misalign & !busy: selected byte/half extended per ld_unsigned to 32 bits; word returned unmodified.
REQ-020 SHALL drive dm_out = 0 when memRead==0, misalign==1 or busy==1.
REQ-021 SHALL return pre-write contents when reading and writing the same address in one cycle; new data visible the cycle after.
REQ-022 SHALL implement FSM states IDLE and CLEAR: rst -> CLEAR with ptr=0; CLEAR writes 0 to word ptr each cycle, ptr increments; CLEAR with ptr==DEPTH-1 -> IDLE; IDLE stays IDLE absent rst.
REQ-023 SHALL assert busy = (state==CLEAR); sweep completes DEPTH cycles after the first cycle rst is low.
REQ-024 SHALL restart the sweep from ptr=0 if rst reasserts mid-sweep.

Reset
REQ-025 SHALL, in any cycle with rst=1, set state=CLEAR, ptr=0, ignore memWrite; rst wins over simultaneous memWrite.
REQ-026 SHALL show busy=1 and dm_out=0 from the edge rst is sampled until sweep ends; memory contents all zero at busy fall.
REQ-027 SHALL leave state undefined before the first rst; no power-up initial block relied on.

Structure
REQ-028 SHALL place size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and FSM state encodings in shared package dm_pkg.
REQ-029 SHALL put lane merge (store byte-enable generation) and load extract/extend in one combinational sub-module dm_lane_align; storage, FSM and counter in dm_sized.
REQ-030 SHALL infer storage as a reg array with per-lane write enables.

Verification
REQ-031 SHALL cover reset sweep: DEPTH=16, preload all words 0xFFFFFFFF, pulse rst 1 cycle -> busy high exactly 16 cycles, then every word reads 0.
REQ-032 SHALL cover byte stores: sw 0x11223344 @0x8, sb 0xAA @0xA -> lw @0x8 = 0x11AA3344; lb @0xA = 0xFFFFFFAA; lbu = 0x000000AA.
REQ-033 SHALL cover halves: sh 0x8001 @0x6 -> lh @0x6 = 0xFFFF8001, lhu = 0x00008001, word @0x4 low half unchanged.
REQ-034 SHALL cover misalign: sw 0x12345678 @0x5, sh @0x3, size=11 -> misalign=1 each, dm_out=0, memory unchanged.
REQ-035 SHALL cover collisions: rst with memWrite same cycle -> no write; rst at sweep ptr=7 -> busy stays DEPTH more cycles; read+write same address -> old data then new.
REQ-036 SHALL cover aliasing: DEPTH=16, sw 0xCAFEF00D @0x40 -> lw @0x0 = 0xCAFEF00D.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared encodings for the sized data memory: access sizes, FSM states and
// the alignment rule used by both the datapath and its users.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int         ST_W     = 1;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // An access is illegal if it straddles its natural boundary or uses the
    // reserved size code.
    function automatic logic size_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            SZ_BYTE: size_misaligned = 1'b0;
            SZ_HALF: size_misaligned = lo[0];
            SZ_WORD: size_misaligned = (lo != 2'b00);
            default: size_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering: store byte-enables and lane-replicated write data, plus
// load extraction with sign/zero extension.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    input  logic [31:0] data_in,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdata
);

    logic [31:0] shifted;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign shifted  = rword >> {lane, 3'b000};
    assign sel_byte = shifted[7:0];
    assign sel_half = lane[1] ? rword[31:16] : rword[15:0];

    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        be    = 4'b0000;
        wdata = data_in;
        rdata = '0;
        case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << lane;
                wdata = {4{data_in[7:0]}};
                rdata = ld_unsigned ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            end
            SZ_HALF: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{data_in[15:0]}};
                rdata = ld_unsigned ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
            end
            SZ_WORD: begin
                be    = 4'b1111;
                rdata = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_sized.sv
// Word-organised data memory with byte/half/word access, zero-latency reads,
// and a clearing sweep after reset that holds off traffic until done.
module dm_sized
    import dm_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    input  logic        memWrite,
    input  logic        memRead,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    output logic [31:0] dm_out,
    output logic        busy,
    output logic        misalign
);

    logic [31:0]      mem [DEPTH];
    logic [ST_W-1:0]  state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx;
    logic [3:0]       be;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic             wr_en;
    logic             unused_addr;

    // Upper address bits alias onto the same words.
    assign idx         = addr[IDX_W+1:2];
    assign unused_addr = ^addr[31:IDX_W+2];

    assign busy     = (state == ST_CLEAR);
    assign misalign = (memRead | memWrite) & size_misaligned(size, addr[1:0]);
    assign wr_en    = memWrite & ~misalign & ~busy;
    assign dm_out   = (memRead & ~misalign & ~busy) ? rdata : '0;

    dm_lane_align u_lane_align (
        .lane        (addr[1:0]),
        .size        (size),
        .ld_unsigned (ld_unsigned),
        .data_in     (data_in),
        .rword       (mem[idx]),
        .be          (be),
        .wdata       (wdata),
        .rdata       (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end else if (state == ST_CLEAR) begin
            ptr <= ptr + IDX_W'(1);
            if (ptr == IDX_W'(DEPTH - 1))
                state <= ST_IDLE;
        end
    end

    // NOTE: the array itself is never reset; the sweep zeroes it one word per
    // cycle, keeping it inferable as plain RAM with per-lane write enables.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR) begin
                mem[ptr] <= '0;
            end else if (wr_en) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule
